// File: rtl/ledctl_pwm.sv
// Memory-mapped LED controller: per-channel static drive or PWM, with a
// shared prescaler, glitch-free duty shadows and a saturating period counter.
module ledctl_pwm #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          NUM_LEDS     = 8,
    parameter int          PWM_BITS     = 8,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                mem_valid,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic [NUM_LEDS-1:0] leds
);

    localparam logic [PWM_BITS-1:0] PWM_ONE = 1;

    logic                hit, accept, wr_en, aligned, tick, wrap;
    logic [9:0]          word;
    logic [31:0]         reg_rd, wr_merged;

    logic                ready_q, ready_d, busy_q, busy_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [NUM_LEDS-1:0] out_q, out_d, mode_q, mode_d, leds_q, leds_d;
    logic [15:0]         prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
    logic [31:0]         periods_q, periods_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q   [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_d   [NUM_LEDS];
    logic [PWM_BITS-1:0] shadow_q [NUM_LEDS];
    logic [PWM_BITS-1:0] shadow_d [NUM_LEDS];

    // busy_q blocks re-acknowledging a request whose valid is simply held on.
    assign hit     = mem_valid && (mem_addr[31:12] == BASE_ADDR[31:12]);
    assign accept  = hit && !busy_q;
    assign wr_en   = accept && (mem_wstrb != 4'b0000);
    assign word    = mem_addr[11:2];
    assign aligned = (mem_addr[1:0] == 2'b00);

    assign tick = (pre_cnt_q >= prescale_q);
    assign wrap = tick && (pwm_cnt_q == '1);

    always_comb begin
        reg_rd = '0;
        if (aligned) begin
            case (word)
                10'd0:   reg_rd = 32'(out_q);
                10'd1:   reg_rd = 32'(mode_q);
                10'd2:   reg_rd = 32'(prescale_q);
                10'd3:   reg_rd = periods_q;
                default: reg_rd = '0;
            endcase
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (word == 10'(64 + i)) reg_rd = 32'(duty_q[i]);
            end
        end
    end

    // Byte-lane merge onto the current readback keeps unwritten lanes intact.
    always_comb begin
        wr_merged = reg_rd;
        for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) wr_merged[8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    always_comb begin
        out_d      = out_q;
        mode_d     = mode_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        shadow_d   = shadow_q;
        periods_d  = periods_q;
        if (wrap) begin
            shadow_d = duty_q;
            if (periods_q != '1) periods_d = periods_q + 32'd1;
        end
        if (wr_en && aligned) begin
            case (word)
                10'd0:   out_d      = wr_merged[NUM_LEDS-1:0];
                10'd1:   mode_d     = wr_merged[NUM_LEDS-1:0];
                10'd2:   prescale_d = wr_merged[15:0];
                10'd3:   periods_d  = '0;
                default: ;
            endcase
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (word == 10'(64 + i)) duty_d[i] = wr_merged[PWM_BITS-1:0];
            end
        end
    end

    always_comb begin
        pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
        pwm_cnt_d = tick ? pwm_cnt_q + PWM_ONE : pwm_cnt_q;
        busy_d    = mem_valid ? (busy_q || accept) : 1'b0;
        ready_d   = accept;
        rdata_d   = (accept && mem_wstrb == 4'b0000) ? reg_rd : '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            leds_d[i] = mode_q[i] ? (pwm_cnt_q < shadow_q[i]) : out_q[i];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
            out_q      <= '0;
            mode_q     <= '0;
            leds_q     <= '0;
            prescale_q <= PRESCALE_RST;
            pre_cnt_q  <= '0;
            periods_q  <= '0;
            pwm_cnt_q  <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
            out_q      <= out_d;
            mode_q     <= mode_d;
            leds_q     <= leds_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            periods_q  <= periods_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            shadow_q   <= shadow_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign leds      = leds_q;

endmodule

// File: doc/ledctl_pwm.md
LEDCTL_PWM -- requirements
Module: ledctl_pwm

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000, base of a 4 KB register window aligned to 4 KB.
REQ-002 Parameter NUM_LEDS, default 8, number of LED channels; legal range 1..16.
REQ-003 Parameter PWM_BITS, default 8, PWM counter and duty width; legal range 1..16.
REQ-004 Parameter PRESCALE_RST, default 16'd0, reset value of the PRESCALE register.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 nrst  input  1  reset, asynchronous and active-low.
REQ-007 mem_valid  input  1  CPU native-bus request valid.
REQ-008 mem_addr  input  32  byte address of the request.
REQ-009 mem_wdata  input  32  write data.
REQ-010 mem_wstrb  input  4  byte write strobes; 4'b0000 means read.
REQ-011 mem_ready  output  1  one-cycle acknowledge.
REQ-012 mem_rdata  output  32  read data; 0 whenever mem_ready is low.
REQ-013 leds  output  NUM_LEDS  registered LED drive.

Function
REQ-014 Hit = mem_valid & (mem_addr[31:12] == BASE_ADDR[31:12]); misses never raise mem_ready, and mem_rdata stays 0, so responses from several slaves can be OR-combined.
REQ-015 A hit with mem_ready low sets mem_ready high on the next edge for exactly one cycle; the cycle after an ack acknowledges nothing, even if mem_valid remains high.
REQ-016 Register map, by offset mem_addr[11:0]: 0x000 OUT[NUM_LEDS-1:0] rw; 0x004 MODE[NUM_LEDS-1:0] rw (bit=1 selects PWM); 0x008 PRESCALE[15:0] rw; 0x00C PERIODS[31:0] ro, a write clears it; 0x100+4*i DUTY_i[PWM_BITS-1:0] rw, for i < NUM_LEDS.
REQ-017 Writes apply only the byte lanes enabled by mem_wstrb; register bits beyond the implemented width read as 0.
REQ-018 Unmapped offsets inside the window are still acknowledged; they read 0 and ignore writes.
REQ-019 Read data is sampled when the request is accepted and is presented with mem_ready.
REQ-020 The prescaler counter increments every cycle; when it is >= PRESCALE it wraps to 0 and emits a one-cycle tick, so PRESCALE=0 gives a tick every cycle.
REQ-021 The PWM counter (PWM_BITS wide) increments on each tick and wraps from all-ones to 0.
REQ-022 Each DUTY_i has an active shadow copy, loaded only on the tick that wraps the PWM counter to 0, so duty changes are glitch-free.
REQ-023 PERIODS increments on each PWM wrap and saturates at 32'hFFFF_FFFF.
REQ-024 If a PERIODS write and a wrap occur in the same cycle, the write wins and PERIODS = 0.
REQ-025 Per channel i, the next leds[i] is OUT[i] when MODE[i]=0, otherwise (pwm_cnt < shadow_duty_i).
REQ-026 Duty 0 gives an LED that is always off; all-ones duty gives an LED that is off for 1 of 2^PWM_BITS counts.
REQ-027 leds updates one cycle after the controlling register or counter changes.
REQ-028 A write to OUT or MODE takes effect on leds on the second edge after acceptance.

Reset
REQ-029 On nrst low, asynchronously: mem_ready=0, mem_rdata=0, leds=0, OUT=0, MODE=0, PRESCALE=PRESCALE_RST, PERIODS=0, all DUTY and shadow registers =0, prescaler and PWM counters =0.
REQ-030 Reset asserted mid-transaction drops mem_ready immediately; no register write from that transaction persists.
REQ-031 After nrst rises, the first hit is acknowledged normally, per REQ-015.

Verification
REQ-032 Write 0x8000_0000 <= 32'h0000_00A5 with wstrb=4'hF -> mem_ready pulses once, leds=8'hA5 on the second edge, and a read returns 32'h0000_00A5.
REQ-033 Hold mem_valid high on a hit for 4 cycles -> exactly one mem_ready pulse; a read to 0x9000_0000 -> no mem_ready and mem_rdata=0.
REQ-034 Write OUT=32'hFFFF_FFFF with wstrb=4'b0010 -> OUT reads 0x0000_FF00 masked to width, i.e. 8'h00 for NUM_LEDS=8.
REQ-035 MODE=1, PRESCALE=0, DUTY_0=64 -> after the next PWM wrap, leds[0] is high for exactly 64 of every 256 cycles, and PERIODS increments every 256 cycles.
REQ-036 Change DUTY_0 from 64 to 200 mid-period -> the current period still shows 64 high cycles, and the next period shows 200.
REQ-037 Assert nrst during an ack cycle with PERIODS=5 -> mem_ready=0 and leds=0 immediately, and PERIODS reads 0 after release.
